fifo_banked_2w: RTL and testbench



---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_bank.sv | 36 +++
 rtl/fifo_depermute_packed.sv | 18 +
 rtl/fifo_depermute_unpacked.sv | 20 ++
 rtl/fifo_permute_unpacked.sv | 19 +
 rtl/fifo_banked_2w.sv | 143 ++++++++++++++
 tb/tb_fifo_banked_2w.sv | 164 ++++++++++++++++
 7 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the 2-wide banked FIFO slice.
//   FIFO_LANES  : number of lanes handled per cycle (fixed at 2)
//   lane_mask_t : packed per-lane mask, thermometer coded (00/01/11)
//   popcount()  : number of set lanes in a thermometer mask
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_LANES = 2;

  typedef logic [FIFO_LANES-1:0] lane_mask_t;

  function automatic logic [1:0] popcount(input lane_mask_t mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]};
  endfunction

endpackage

// File: rtl/fifo_bank.sv
// ---------------------------------------------------------------------------
// fifo_bank
// ROWS x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   i_clk     : clock, rising edge
//   i_we      : write enable
//   i_wr_row  : write row
//   i_wr_data : write data
//   i_rd_row  : read row
//   o_rd_data : read data (combinational from storage)
// ---------------------------------------------------------------------------
module fifo_bank #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [$clog2(ROWS)-1:0] i_wr_row,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic [$clog2(ROWS)-1:0] i_rd_row,
  output logic [WIDTH-1:0]        o_rd_data
);

  logic [WIDTH-1:0] mem_q [0:ROWS-1];

  // NOTE: storage has no reset; occupancy tracking makes stale rows invisible,
  // and leaving it out keeps the array a plain register file.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_wr_row] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_row];

endmodule

// File: rtl/fifo_depermute_packed.sv
// ---------------------------------------------------------------------------
// fifo_depermute_packed
// Lane-to-bank rotation of a packed 2-bit mask (write enables).
//   i_shift : rotation amount (write pointer low bit)
//   i_mask  : per-lane mask
//   o_mask  : per-bank mask
// ---------------------------------------------------------------------------
module fifo_depermute_packed
  import fifo_pkg::*;
(
  input  logic       i_shift,
  input  lane_mask_t i_mask,
  output lane_mask_t o_mask
);

  assign o_mask = i_shift ? {i_mask[0], i_mask[1]} : i_mask;

endmodule

// File: rtl/fifo_depermute_unpacked.sv
// ---------------------------------------------------------------------------
// fifo_depermute_unpacked
// Lane-to-bank rotation for two lanes: o_data[(k + i_shift) % 2] = i_data[k].
// With two lanes the inverse rotation is also a conditional swap.
//   i_shift : rotation amount (pointer low bit)
//   i_data  : per-lane inputs
//   o_data  : per-bank outputs
// ---------------------------------------------------------------------------
module fifo_depermute_unpacked #(
  parameter int WIDTH = 32
) (
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data [0:1],
  output logic [WIDTH-1:0] o_data [0:1]
);

  assign o_data[0] = i_shift ? i_data[1] : i_data[0];
  assign o_data[1] = i_shift ? i_data[0] : i_data[1];

endmodule

// File: rtl/fifo_permute_unpacked.sv
// ---------------------------------------------------------------------------
// fifo_permute_unpacked
// Bank-to-lane rotation for two lanes: o_data[k] = i_data[(k + i_shift) % 2].
//   i_shift : rotation amount (read pointer low bit)
//   i_data  : per-bank inputs
//   o_data  : per-lane outputs
// ---------------------------------------------------------------------------
module fifo_permute_unpacked #(
  parameter int WIDTH = 32
) (
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data [0:1],
  output logic [WIDTH-1:0] o_data [0:1]
);

  assign o_data[0] = i_shift ? i_data[1] : i_data[0];
  assign o_data[1] = i_shift ? i_data[0] : i_data[1];

endmodule

// File: rtl/fifo_banked_2w.sv
// ---------------------------------------------------------------------------
// fifo_banked_2w
// Two-lane, two-bank in-order FIFO. Up to two entries enqueued and two
// dequeued per cycle. Even/odd banks are addressed by pointer bit 0; lanes
// are rotated into banks on write and back out on read.
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_enq_valid  : enqueue lane mask (thermometer)
//   i_enq_data   : enqueue data, lane 0 oldest
//   o_enq_ready  : bit k set iff free slots >= k+1
//   o_deq_valid  : bit k set iff occupancy >= k+1
//   o_deq_data   : two oldest entries, lane 0 oldest (combinational)
//   i_deq_ack    : dequeue mask (thermometer, subset of o_deq_valid)
//   o_count      : current occupancy
// Optional: define FIFO_BANKED_ASSERT_EN to compile protocol/state checks.
// ---------------------------------------------------------------------------
module fifo_banked_2w
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  lane_mask_t               i_enq_valid,
  input  logic [WIDTH-1:0]         i_enq_data [0:FIFO_LANES-1],
  output lane_mask_t               o_enq_ready,
  output lane_mask_t               o_deq_valid,
  output logic [WIDTH-1:0]         o_deq_data [0:FIFO_LANES-1],
  input  lane_mask_t               i_deq_ack,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int RW   = PW - 1;
  localparam int ROWS = DEPTH / 2;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_nx1, rd_ptr_nx1;
  lane_mask_t    enq_acc, deq_acc, bank_we;

  logic [RW-1:0]    lane_wr_row [0:1];
  logic [RW-1:0]    bank_wr_row [0:1];
  logic [RW-1:0]    lane_rd_row [0:1];
  logic [RW-1:0]    bank_rd_row [0:1];
  logic [WIDTH-1:0] bank_wr_data [0:1];
  logic [WIDTH-1:0] bank_rd_data [0:1];

  // Status depends on registered count only.
  assign o_enq_ready = {count_q <= CW'(DEPTH - 2), count_q < CW'(DEPTH)};
  assign o_deq_valid = {count_q >= CW'(2), count_q != '0};
  assign o_count     = count_q;

  // NOTE: every always_comb output gets a value on every path (defaults
  // first) so no latch is inferred.
  always_comb begin
    enq_acc    = i_enq_valid & o_enq_ready;
    deq_acc    = i_deq_ack & o_deq_valid;
    // Lane 1 only counts behind lane 0, so a 10 mask cannot skew count.
    enq_acc[1] = enq_acc[1] & enq_acc[0];
    deq_acc[1] = deq_acc[1] & deq_acc[0];
    wr_ptr_d   = wr_ptr_q + PW'(popcount(enq_acc));
    rd_ptr_d   = rd_ptr_q + PW'(popcount(deq_acc));
    count_d    = count_q + CW'(popcount(enq_acc)) - CW'(popcount(deq_acc));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Rows come from the pointer and pointer+1 modulo DEPTH, so a pair
  // straddling DEPTH-1 -> 0 lands in the right rows.
  assign wr_ptr_nx1     = wr_ptr_q + PW'(1);
  assign rd_ptr_nx1     = rd_ptr_q + PW'(1);
  assign lane_wr_row[0] = wr_ptr_q[PW-1:1];
  assign lane_wr_row[1] = wr_ptr_nx1[PW-1:1];
  assign lane_rd_row[0] = rd_ptr_q[PW-1:1];
  assign lane_rd_row[1] = rd_ptr_nx1[PW-1:1];

  fifo_depermute_unpacked #(.WIDTH(WIDTH)) u_wr_data_dp (
    .i_shift(wr_ptr_q[0]), .i_data(i_enq_data), .o_data(bank_wr_data)
  );

  fifo_depermute_unpacked #(.WIDTH(RW)) u_wr_row_dp (
    .i_shift(wr_ptr_q[0]), .i_data(lane_wr_row), .o_data(bank_wr_row)
  );

  fifo_depermute_packed u_wr_en_dp (
    .i_shift(wr_ptr_q[0]), .i_mask(enq_acc), .o_mask(bank_we)
  );

  // Read rows use the same lane-to-bank routing: the even bank gets
  // whichever of rd_ptr / rd_ptr+1 is even.
  fifo_depermute_unpacked #(.WIDTH(RW)) u_rd_row_dp (
    .i_shift(rd_ptr_q[0]), .i_data(lane_rd_row), .o_data(bank_rd_row)
  );

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fifo_bank #(.WIDTH(WIDTH), .ROWS(ROWS)) u_bank (
      .i_clk    (i_clk),
      .i_we     (bank_we[b]),
      .i_wr_row (bank_wr_row[b]),
      .i_wr_data(bank_wr_data[b]),
      .i_rd_row (bank_rd_row[b]),
      .o_rd_data(bank_rd_data[b])
    );
  end

  fifo_permute_unpacked #(.WIDTH(WIDTH)) u_rd_data_p (
    .i_shift(rd_ptr_q[0]), .i_data(bank_rd_data), .o_data(o_deq_data)
  );

`ifdef FIFO_BANKED_ASSERT_EN
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_banked_2w: DEPTH must be a power of two and >= 4");
  end

  a_enq_mask: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_enq_valid != 2'b10);
  a_deq_mask: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_deq_ack != 2'b10);
  a_deq_ovr: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_deq_ack & ~o_deq_valid) == '0);
  a_cnt_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count_q <= CW'(DEPTH));
  a_cnt_ptr: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (count_q == CW'(DEPTH)) ? (wr_ptr_q == rd_ptr_q)
                            : (count_q == {1'b0, PW'(wr_ptr_q - rd_ptr_q)}));
`endif

endmodule

// File: tb/tb_fifo_banked_2w.sv
// ---------------------------------------------------------------------------
// tb_fifo_banked_2w
// Directed bench for fifo_banked_2w (WIDTH=32, DEPTH=8): reset, basic
// enqueue/dequeue, odd read pointer, wrap-around, full boundary,
// simultaneous enqueue+dequeue and asynchronous mid-operation reset.
// ---------------------------------------------------------------------------
module tb_fifo_banked_2w;
  import fifo_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  lane_mask_t       enq_valid;
  logic [WIDTH-1:0] enq_data [0:1];
  lane_mask_t       enq_ready;
  lane_mask_t       deq_valid;
  logic [WIDTH-1:0] deq_data [0:1];
  lane_mask_t       deq_ack;
  logic [3:0]       count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_banked_2w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enq_valid(enq_valid),
    .i_enq_data (enq_data),
    .o_enq_ready(enq_ready),
    .o_deq_valid(deq_valid),
    .o_deq_data (deq_data),
    .i_deq_ack  (deq_ack),
    .o_count    (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [3:0] c,
                              input logic [1:0] v, input logic [1:0] r);
    check({tag, ".count"}, 64'(count), 64'(c));
    check({tag, ".deq_valid"}, 64'(deq_valid), 64'(v));
    check({tag, ".enq_ready"}, 64'(enq_ready), 64'(r));
  endtask

  task automatic check_data(input string tag, input logic [31:0] d0, input logic [31:0] d1);
    check({tag, ".d0"}, 64'(deq_data[0]), 64'(d0));
    check({tag, ".d1"}, 64'(deq_data[1]), 64'(d1));
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic [1:0] ev, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [1:0] ack);
    enq_valid   = ev;
    enq_data[0] = d0;
    enq_data[1] = d1;
    deq_ack     = ack;
    @(posedge clk);
    #1;
    enq_valid = 2'b00;
    deq_ack   = 2'b00;
  endtask

  initial begin
    rst_n       = 1'b0;
    enq_valid   = 2'b00;
    deq_ack     = 2'b00;
    enq_data[0] = '0;
    enq_data[1] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_status("reset", 4'd0, 2'b00, 2'b11);
    rst_n = 1'b1;

    // Basic: A,B then C; read with even and then odd rd_ptr
    step(2'b11, 32'hA, 32'hB, 2'b00);
    check_status("enq_ab", 4'd2, 2'b11, 2'b11);
    check_data("enq_ab", 32'hA, 32'hB);
    step(2'b01, 32'hC, 32'h0, 2'b00);
    check_status("enq_c", 4'd3, 2'b11, 2'b11);
    check_data("enq_c", 32'hA, 32'hB);
    step(2'b00, 32'h0, 32'h0, 2'b01);            // rd=1 wr=3
    check_status("ack1", 4'd2, 2'b11, 2'b11);
    check_data("ack1_odd_rd", 32'hB, 32'hC);

    // Advance pointers toward the wrap with mixed 1/2 traffic
    step(2'b11, 32'hD, 32'hE, 2'b11);            // rd=3 wr=5
    check_status("mix1", 4'd2, 2'b11, 2'b11);
    check_data("mix1", 32'hD, 32'hE);
    step(2'b01, 32'hF, 32'h0, 2'b01);            // rd=4 wr=6
    check_data("mix2", 32'hE, 32'hF);
    step(2'b01, 32'h6, 32'h0, 2'b11);            // rd=6 wr=7
    check_status("mix3", 4'd1, 2'b01, 2'b11);
    check("mix3.d0", 64'(deq_data[0]), 64'h6);

    // Wrap: X at ptr 7 (odd bank row 3), Y at ptr 0 (even bank row 0)
    step(2'b11, 32'h1111_0007, 32'h2222_0000, 2'b00);  // wr=1
    check_status("wrap_enq", 4'd3, 2'b11, 2'b11);
    check_data("wrap_enq", 32'h6, 32'h1111_0007);
    step(2'b00, 32'h0, 32'h0, 2'b01);            // rd=7
    check_data("wrap_deq", 32'h1111_0007, 32'h2222_0000);
    step(2'b00, 32'h0, 32'h0, 2'b11);            // rd=1
    check_status("wrap_empty", 4'd0, 2'b00, 2'b11);

    // Full boundary
    step(2'b11, 32'h50, 32'h51, 2'b00);
    step(2'b11, 32'h52, 32'h53, 2'b00);
    step(2'b11, 32'h54, 32'h55, 2'b00);
    check_status("fill6", 4'd6, 2'b11, 2'b11);
    step(2'b01, 32'h56, 32'h0, 2'b00);
    check_status("fill7", 4'd7, 2'b11, 2'b01);
    step(2'b11, 32'h57, 32'h58, 2'b00);          // only lane 0 accepted
    check_status("full", 4'd8, 2'b11, 2'b00);
    step(2'b11, 32'hBAD0, 32'hBAD1, 2'b00);      // rejected entirely
    check_status("full_hold", 4'd8, 2'b11, 2'b00);
    for (int i = 0; i < 4; i++) begin
      check_data("drain_full", 32'h50 + 32'(2 * i), 32'h51 + 32'(2 * i));
      step(2'b00, 32'h0, 32'h0, 2'b11);
    end
    check_status("drained", 4'd0, 2'b00, 2'b11);

    // Simultaneous enqueue + dequeue at count 4
    step(2'b11, 32'h60, 32'h61, 2'b00);
    step(2'b11, 32'h62, 32'h63, 2'b00);
    check_status("sim_pre", 4'd4, 2'b11, 2'b11);
    step(2'b11, 32'h64, 32'h65, 2'b11);
    check_status("sim", 4'd4, 2'b11, 2'b11);
    for (int i = 0; i < 4; i++) begin
      check("sim_order", 64'(deq_data[0]), 64'(32'h62 + 32'(i)));
      step(2'b00, 32'h0, 32'h0, 2'b01);
    end
    check_status("sim_empty", 4'd0, 2'b00, 2'b11);

    // Asynchronous reset in the middle of a cycle at count 5
    step(2'b11, 32'h70, 32'h71, 2'b00);
    step(2'b11, 32'h72, 32'h73, 2'b00);
    step(2'b01, 32'h74, 32'h0, 2'b00);
    check_status("pre_rst", 4'd5, 2'b11, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_status("mid_rst", 4'd0, 2'b00, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 32'h80, 32'h81, 2'b00);
    check_status("post_rst", 4'd2, 2'b11, 2'b11);
    check_data("post_rst", 32'h80, 32'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
